// File: rtl/mem_responder_pkg.sv
// Shared types and limits for the single-word memory responder.
// Imported by the responder top and its latency checks.
package mem_responder_types;

   localparam int unsigned MAX_LATENCY = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Kind of the accepted request; ERR marks read and write asserted together.
   typedef enum logic [1:0] {
      KIND_READ  = 2'd0,
      KIND_WRITE = 2'd1,
      KIND_ERR   = 2'd2
   } kind_t;

   function automatic bit latency_ok(input int unsigned lat);
      return (lat >= 1) && (lat <= MAX_LATENCY);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU single-word memory interface; the CPU drives the master side,
// the responder sits on the slave side.
interface mem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   modport master (
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

// File: rtl/mem_responder_be_word_ram.sv
// Byte-enabled 32-bit word array with a registered read port.
// Contents are never reset.
module be_word_ram #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time, answers it after a fixed
// LATENCY with a single-cycle mem_resp strobe, backed by an on-chip word array.
module mem_responder
   import mem_responder_types::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 3
) (
   input  logic             clk,
   input  logic             rst,
   mem_responder_if.slave   bus,
   output logic             proto_err
);

   if (!latency_ok(LATENCY)) begin : g_bad_latency
      $fatal(1, "mem_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
   end

   localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

   state_t                state_q, state_d;
   logic [3:0]            count_q, count_d;
   kind_t                 kind_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [3:0]            be_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_hold_q;
   logic                  proto_err_q;

   logic                  req;
   logic                  accept;
   kind_t                 kind_in;
   kind_t                 cur_kind;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic [3:0]            cur_be;
   logic [31:0]           cur_wdata;
   logic                  enter_resp;
   logic                  ram_we;
   logic [31:0]           ram_rdata;
   logic                  unused_addr;

   assign req     = bus.mem_read | bus.mem_write;
   assign accept  = (state_q == IDLE) && req;
   assign kind_in = (bus.mem_read && bus.mem_write) ? KIND_ERR  :
                    bus.mem_read                    ? KIND_READ : KIND_WRITE;

   // With LATENCY==1 the array is accessed on the accepting edge itself, so
   // while idle the live bus fields feed the array instead of the latches.
   assign cur_kind  = (state_q == IDLE) ? kind_in : kind_q;
   assign cur_idx   = (state_q == IDLE) ? bus.mem_address[ADDR_WIDTH+1:2] : idx_q;
   assign cur_be    = (state_q == IDLE) ? bus.mem_byte_enable : be_q;
   assign cur_wdata = (state_q == IDLE) ? bus.mem_wdata : wdata_q;

   assign enter_resp = (state_d == RESP) && (state_q != RESP);
   assign ram_we     = enter_resp && (cur_kind == KIND_WRITE) && !rst;

   assign unused_addr = ^{bus.mem_address[31:ADDR_WIDTH+2], bus.mem_address[1:0]};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               count_d = COUNT_INIT;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (count_q <= 4'd1) begin
               count_d = 4'd0;
               state_d = RESP;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= 4'd0;
         kind_q       <= KIND_READ;
         idx_q        <= '0;
         be_q         <= 4'd0;
         wdata_q      <= 32'd0;
         rdata_hold_q <= 32'd0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (accept) begin
            kind_q  <= kind_in;
            idx_q   <= cur_idx;
            be_q    <= bus.mem_byte_enable;
            wdata_q <= bus.mem_wdata;
            if (kind_in == KIND_ERR) proto_err_q <= 1'b1;
         end
         if ((state_q == RESP) && (kind_q == KIND_READ)) rdata_hold_q <= ram_rdata;
      end
   end

   be_word_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (cur_be),
      .addr  (cur_idx),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   // Read data lives in the array's output register during RESP, then is held.
   assign bus.mem_rdata = ((state_q == RESP) && (kind_q == KIND_READ)) ? ram_rdata : rdata_hold_q;
   assign bus.mem_resp  = (state_q == RESP);
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=3 and LATENCY=1 instances,
// scoreboard queue of expected read data popped on each response.
module tb_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic perr3, perr1;

   mem_responder_if if3 ();
   mem_responder_if if1 ();

   mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u3 (
      .clk       (clk),
      .rst       (rst),
      .bus       (if3.slave),
      .proto_err (perr3)
   );

   mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (if1.slave),
      .proto_err (perr1)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model3 [int];
   logic [31:0] last_rd3 = 32'h0;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   task automatic idle3();
      if3.mem_read = 1'b0; if3.mem_write = 1'b0; if3.mem_byte_enable = 4'h0;
      if3.mem_address = 32'h0; if3.mem_wdata = 32'h0;
   endtask

   task automatic idle1();
      if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_byte_enable = 4'h0;
      if1.mem_address = 32'h0; if1.mem_wdata = 32'h0;
   endtask

   // One transaction on the LATENCY=3 instance, started on a negedge.
   task automatic txn3(input logic rd, input logic wr, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit drop_early, input string name);
      int          cyc;
      logic        seen;
      int          idx;
      logic [31:0] exp;
      idx = int'(addr[11:2]);
      if3.mem_read = rd; if3.mem_write = wr; if3.mem_byte_enable = be;
      if3.mem_address = addr; if3.mem_wdata = wdata;
      if (rd && !wr) exp_q.push_back(model3.exists(idx) ? model3[idx] : 32'h0);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
         @(posedge clk); @(negedge clk);
         cyc++;
         seen = if3.mem_resp;
         if (drop_early && cyc == 1 && !seen) begin
            idle3();
            if3.mem_wdata = ~wdata;
            if3.mem_byte_enable = ~be;
         end
      end
      checks++;
      if (!seen || cyc != 3) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles (seen=%0b), expected 3", name, cyc, seen);
      end
      if (seen) begin
         checks++;
         if (rd && !wr) begin
            exp = exp_q.pop_front();
            if (if3.mem_rdata !== exp) begin
               errors++;
               $display("FAIL %s rdata: got %h, expected %h", name, if3.mem_rdata, exp);
            end
            last_rd3 = exp;
         end else if (if3.mem_rdata !== last_rd3) begin
            errors++;
            $display("FAIL %s rdata held: got %h, expected %h", name, if3.mem_rdata, last_rd3);
         end
         if (wr && !rd) model3[idx] = merge(model3.exists(idx) ? model3[idx] : 32'h0, wdata, be);
      end else begin
         exp_q.delete();
      end
      idle3();
      @(posedge clk); @(negedge clk);
      checks++;
      if (if3.mem_resp !== 1'b0) begin
         errors++;
         $display("FAIL %s strobe width: resp got %b, expected 0", name, if3.mem_resp);
      end
   endtask

   task automatic test_reset();
      idle3(); idle1();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks += 6;
      if (if3.mem_resp !== 1'b0) begin errors++; $display("FAIL reset resp3: got %b, expected 0", if3.mem_resp); end
      if (if3.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset rdata3: got %h, expected 0", if3.mem_rdata); end
      if (perr3 !== 1'b0) begin errors++; $display("FAIL reset perr3: got %b, expected 0", perr3); end
      if (if1.mem_resp !== 1'b0) begin errors++; $display("FAIL reset resp1: got %b, expected 0", if1.mem_resp); end
      if (if1.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset rdata1: got %h, expected 0", if1.mem_rdata); end
      if (perr1 !== 1'b0) begin errors++; $display("FAIL reset perr1: got %b, expected 0", perr1); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (if3.mem_resp !== 1'b0) begin errors++; $display("FAIL post-reset resp3: got %b, expected 0", if3.mem_resp); end
   endtask

   task automatic test_basic();
      txn3(1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, "basic_wr");
      txn3(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, "basic_rd");
   endtask

   task automatic test_byte_lanes();
      txn3(1'b0, 1'b1, 4'hF, 32'h40, 32'h11223344, 1'b0, "lanes_wr_full");
      txn3(1'b0, 1'b1, 4'h5, 32'h40, 32'hAABBCCDD, 1'b0, "lanes_wr_0101");
      txn3(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, "lanes_rd");
      checks++;
      if (last_rd3 !== 32'h11BB33DD) begin errors++; $display("FAIL lanes model: got %h, expected 11bb33dd", last_rd3); end
      txn3(1'b0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 1'b0, "lanes_wr_none");
      txn3(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, "lanes_rd_none");
   endtask

   task automatic test_latched();
      txn3(1'b0, 1'b1, 4'hF, 32'h20, 32'h0BADF00D, 1'b1, "latched_wr");
      txn3(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, "latched_rd");
      txn3(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, "latched_word0");
   endtask

   task automatic test_alias();
      txn3(1'b0, 1'b1, 4'hF, 32'h0, 32'hC0FFEE00, 1'b0, "alias_wr0");
      txn3(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, "alias_rd1000");
      checks++;
      if (last_rd3 !== 32'hC0FFEE00) begin errors++; $display("FAIL alias model: got %h, expected c0ffee00", last_rd3); end
      txn3(1'b1, 1'b0, 4'hF, 32'h3, 32'h0, 1'b0, "alias_rd3");
   endtask

   task automatic test_proto_err();
      checks++;
      if (perr3 !== 1'b0) begin errors++; $display("FAIL proto pre: got %b, expected 0", perr3); end
      txn3(1'b1, 1'b1, 4'hF, 32'h100, 32'h55555555, 1'b0, "proto_both");
      checks++;
      if (perr3 !== 1'b1) begin errors++; $display("FAIL proto set: got %b, expected 1", perr3); end
      repeat (5) @(negedge clk);
      txn3(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, "proto_readback");
      checks++;
      if (perr3 !== 1'b1) begin errors++; $display("FAIL proto sticky: got %b, expected 1", perr3); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      logic [31:0] data  [4];
      logic        is_wr [4];
      int          cyc;
      logic        seen;
      logic [31:0] exp;
      addrs = '{32'h0, 32'h4, 32'h0, 32'h4};
      data  = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 32'h0};
      is_wr = '{1'b1, 1'b1, 1'b0, 1'b0};
      exp_q.push_back(data[0]);
      exp_q.push_back(data[1]);
      for (int i = 0; i < 4; i++) begin
         if1.mem_read = !is_wr[i]; if1.mem_write = is_wr[i]; if1.mem_byte_enable = 4'hF;
         if1.mem_address = addrs[i]; if1.mem_wdata = data[i];
         seen = 1'b0;
         cyc  = 0;
         while (!seen && cyc < 20) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            seen = if1.mem_resp;
         end
         checks++;
         if (!seen || cyc != ((i == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL b2b op%0d spacing: got %0d cycles (seen=%0b), expected %0d",
                     i, cyc, seen, (i == 0) ? 1 : 2);
         end
         if (seen && !is_wr[i]) begin
            exp = exp_q.pop_front();
            checks++;
            if (if1.mem_rdata !== exp) begin
               errors++;
               $display("FAIL b2b op%0d rdata: got %h, expected %h", i, if1.mem_rdata, exp);
            end
         end
      end
      idle1();
      @(posedge clk); @(negedge clk);
      checks++;
      if (if1.mem_resp !== 1'b0) begin errors++; $display("FAIL b2b tail resp: got %b, expected 0", if1.mem_resp); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic saw;
      txn3(1'b0, 1'b1, 4'hF, 32'h8, 32'h13579BDF, 1'b0, "rstmid_seed");
      txn3(1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, "rstmid_seed_rd");
      if3.mem_write = 1'b1; if3.mem_byte_enable = 4'hF;
      if3.mem_address = 32'h8; if3.mem_wdata = 32'h12345678;
      @(posedge clk); @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks += 3;
      if (if3.mem_resp !== 1'b0) begin errors++; $display("FAIL rstmid resp: got %b, expected 0", if3.mem_resp); end
      if (if3.mem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid rdata: got %h, expected 0", if3.mem_rdata); end
      if (perr3 !== 1'b0) begin errors++; $display("FAIL rstmid perr: got %b, expected 0", perr3); end
      idle3();
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      last_rd3 = 32'h0;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (if3.mem_resp) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin errors++; $display("FAIL rstmid stray resp: got %b, expected 0", saw); end
      txn3(1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, "rstmid_readback");
   endtask

   initial begin
      idle3();
      idle1();
      test_reset();
      test_basic();
      test_byte_lanes();
      test_latched();
      test_alias();
      test_proto_err();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder (slave) end of the CPU's single-word memory interface: mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in, mem_rdata/mem_resp out.
- Backs the interface with an on-chip word array.
- Inserts a programmable fixed latency so CPU control-FSM wait states and MDR load timing are exercised.
- Sits between the RV32I datapath/control and (later) the cache; used standalone in CPU-level benches.

Parameters:
- ADDR_WIDTH, 10, number of word-address bits; the array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_read  input  1  read request, held by the CPU until mem_resp.
- mem_write  input  1  write request, held by the CPU until mem_resp.
- mem_byte_enable  input  4  write byte lanes; bit i enables bits 8i+7:8i.
- mem_address  input  32  byte address; bits 1:0 ignored; word index = bits ADDR_WIDTH+1:2; upper bits ignored (aliasing).
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data, valid in the mem_resp cycle.
- mem_resp  output  1  single-cycle completion strobe.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sampled deassert on clk):
  - state=IDLE, count=0, mem_resp=0, mem_rdata=0, proto_err=0.
  - Array contents are not reset.
- State machine (state_t):
  - IDLE:
    - mem_read|mem_write high at an edge: latch address index, rdwr kind, byte enables and wdata; count=LATENCY-1.
    - Go to RESP if LATENCY==1, else WAIT.
  - WAIT: count decrements each edge; when count reaches 1, the next edge goes to RESP.
  - RESP: mem_resp=1 for exactly this cycle; next edge returns to IDLE.
- Latency: request sampled at edge E; mem_resp is high in the cycle following edge E+LATENCY-1, i.e. exactly LATENCY cycles after the request is first seen.
- Back-to-back: the IDLE cycle after RESP may accept a new request immediately. Minimum spacing between resp strobes is LATENCY+1 cycles.
- Latched request:
  - Inputs are latched at acceptance; changes during WAIT/RESP are ignored.
  - A request dropped early still completes (resp still pulses).
- Read: mem_rdata is loaded on the edge entering RESP with array[index]. It holds that value until the next read response; writes never change mem_rdata.
- Write:
  - Commit occurs on the edge entering RESP, only lanes with byte_enable=1.
  - byte_enable=0000: no array change, response still given.
  - A read of the same word on the next transaction returns the new data.
- mem_read and mem_write both high at acceptance:
  - proto_err set (sticky until rst).
  - No array access, mem_rdata unchanged.
  - Response still given after LATENCY so the CPU does not hang.
- Reset mid-transaction: transaction abandoned, no resp, no write commit (commit happens only at RESP entry).
- mem_resp is never high in two consecutive cycles.

Decomposition:
- Package mem_responder_types:
  - state_t enum {IDLE, WAIT, RESP}.
  - MAX_LATENCY=15 constant.
  - LATENCY range check via elaboration-time $fatal.
- Sub-module be_word_ram:
  - Synchronous byte-enabled word array, ports clk, we, be[3:0], addr[ADDR_WIDTH-1:0], wdata, rdata.
  - Registered read; no reset.
- FSM and latch registers stay in mem_responder.

Test Plan:
- LATENCY=3, rst 1->0, then write 0xDEADBEEF to 0x100 with be=1111, then read 0x100 -> resp exactly 3 cycles after each request, single-cycle strobe; read returns 0xDEADBEEF.
- Write 0x11223344 to 0x40 (be=1111), then write 0xAABBCCDD to 0x40 with be=0101, then read -> 0x11BB33DD.
- LATENCY=1: back-to-back reads of 0x0 and 0x4 with read held high continuously -> resp every 2 cycles, correct data each; no resp in consecutive cycles.
- Assert mem_read and mem_write together -> proto_err=1 and stays 1, resp after LATENCY, mem_rdata unchanged, array unchanged on readback.
- Write 0x12345678 to 0x8 with rst asserted asynchronously in WAIT (mid-cycle) -> mem_resp=0, mem_rdata=0 immediately, no resp; a later read of 0x8 returns the old content.
- Read 0x1000 with ADDR_WIDTH=10 -> aliases to word 0; returns word-0 data; address bits 1:0 = 2'b11 give the same word.
